// File: rtl/alu16_driver.sv
// rtl/alu16_driver.sv - request/response sequencer for the alu16 start/count/out interface
module alu16_driver #(
    parameter int WIDTH      = 16,
    parameter int OPW        = 3,
    parameter int LAST_COUNT = 15,
    parameter int START_CYC  = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             alu_on,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH:0]   alu_out,
    input  logic [3:0]       alu_count
);

    localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   start_cnt;
    logic [TW-1:0]   timer;
    logic            arm;

    logic            accept;
    logic            start_done;
    logic            done_hit;
    logic            time_hit;
    logic            rsp_take;

    // Outputs decode straight from state so reset drops alu_on with no clock.
    assign req_ready  = (state == S_IDLE);
    assign alu_on     = (state == S_START);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    assign accept     = req_valid && req_ready;
    assign start_done = (start_cnt == SW'(START_CYC - 1));
    // arm is the registered flag, so a LAST_COUNT left over from the previous
    // operation can never complete this one before the counter has moved.
    assign done_hit   = arm && (alu_count == 4'(LAST_COUNT));
    assign time_hit   = (timer == TW'(TIMEOUT - 1));
    assign rsp_take   = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; completion is tested ahead of timeout so it wins a tie.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)     state_nxt = S_START;
            S_START: if (start_done) state_nxt = S_WAIT;
            S_WAIT:  if (done_hit || time_hit) state_nxt = S_RESP;
            S_RESP:  if (rsp_take)   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, start/wait timers, arm flag and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ina     <= '0;
            alu_inb     <= '0;
            alu_op      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            start_cnt   <= '0;
            timer       <= '0;
            arm         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_ina   <= req_a;
                        alu_inb   <= req_b;
                        alu_op    <= req_op;
                        start_cnt <= '0;
                    end
                end
                S_START: begin
                    start_cnt <= start_cnt + SW'(1);
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (alu_count != 4'(LAST_COUNT)) begin
                        arm <= 1'b1;
                    end
                    if (done_hit) begin
                        rsp_data    <= alu_out;
                        rsp_timeout <= 1'b0;
                    end else if (time_hit) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_take) begin
                        rsp_timeout <= 1'b0;
                        timer       <= '0;
                        arm         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_driver.sv
// tb/tb_alu16_driver.sv - scoreboard bench for alu16_driver against an alu16 stub
module tb_alu16_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [16:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        alu_on;
    logic [15:0] alu_ina;
    logic [15:0] alu_inb;
    logic [2:0]  alu_op;
    logic [16:0] alu_out = '0;
    logic [3:0]  alu_count = 4'd15;
    logic        freeze = 1'b0;

    int total = 0;
    int bad = 0;
    int on_cyc = 0;
    int wait_cyc = 0;

    typedef struct {
        logic [16:0] data;
        logic        to;
    } exp_t;
    exp_t sb[$];

    alu16_driver dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .alu_on(alu_on),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_op(alu_op),
        .alu_out(alu_out), .alu_count(alu_count)
    );

    always #5 clk = ~clk;

    // alu16 stub: on restarts count at 0, count runs to 15 and holds; the
    // sum appears when count reaches 15, otherwise alu_out keeps its old value.
    always @(posedge clk) begin
        if (!freeze) begin
            if (alu_on) begin
                alu_count <= 4'd0;
            end else if (alu_count != 4'd15) begin
                alu_count <= alu_count + 4'd1;
                if (alu_count == 4'd14)
                    alu_out <= {1'b0, alu_ina} + {1'b0, alu_inb};
            end
        end
    end

    // Per-operation counters of alu_on cycles and WAIT cycles.
    always @(posedge clk) begin
        if (req_valid && req_ready) begin
            on_cyc   = 0;
            wait_cyc = 0;
        end else begin
            if (alu_on) on_cyc++;
            if (busy && !alu_on && !rsp_valid) wait_cyc++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic exp_to, input logic push);
        exp_t e;
        @(negedge clk);
        check_val("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_a     = a;
        req_b     = b;
        req_op    = 3'b000;
        req_valid = 1'b1;
        if (push) begin
            e.data = exp_to ? 17'd0 : ({1'b0, a} + {1'b0, b});
            e.to   = exp_to;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int hold);
        exp_t        e;
        int          n;
        logic [16:0] held;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check_val({tag, "_data"}, {15'd0, rsp_data}, {15'd0, e.data});
            check_val({tag, "_to"}, {31'd0, rsp_timeout}, {31'd0, e.to});
            held = rsp_data;
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check_val({tag, "_stable"}, {15'd0, rsp_data}, {15'd0, held});
                check_val({tag, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
                check_val({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
                check_val({tag, "_stall_valid"}, {31'd0, rsp_valid}, 32'd1);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            check_val({tag, "_rel_valid"}, {31'd0, rsp_valid}, 32'd0);
            check_val({tag, "_rel_ready"}, {31'd0, req_ready}, 32'd1);
            check_val({tag, "_rel_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_alu_on", {31'd0, alu_on}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_data", {15'd0, rsp_data}, 32'd0);
        check_val("rst_alu_ina", {16'd0, alu_ina}, 32'd0);
        rst_n = 1'b1;

        // basic add
        send(16'h00C7, 16'h0021, 1'b0, 1'b1);
        get_rsp("add", 0);
        check_val("add_on_cycles", on_cyc, 32'd2);

        // back-to-back with count left at 15 and stale alu_out
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        get_rsp("b2b", 0);
        check_val("b2b_on_cycles", on_cyc, 32'd2);

        // timeout: stub frozen at count 15
        freeze = 1'b1;
        send(16'h0005, 16'h0006, 1'b1, 1'b1);
        get_rsp("tmo", 0);
        check_val("tmo_wait_cycles", wait_cyc, 32'd32);
        freeze = 1'b0;

        // consumer stall in RESP
        send(16'h0010, 16'h0020, 1'b0, 1'b1);
        get_rsp("stall", 10);

        // request input wiggles during WAIT are ignored
        send(16'h0100, 16'h0002, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!(busy && !alu_on && !rsp_valid) && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        req_a     = 16'h7777;
        req_valid = 1'b1;
        @(negedge clk);
        check_val("latch_ina", {16'd0, alu_ina}, 32'h0100);
        check_val("latch_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        get_rsp("latch", 0);

        // reset in the middle of START
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        check_val("mid_alu_on_pre", {31'd0, alu_on}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_alu_on", {31'd0, alu_on}, 32'd0);
        check_val("mid_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("mid_alu_ina", {16'd0, alu_ina}, 32'd0);
        check_val("mid_rsp_to", {31'd0, rsp_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // recovery after reset
        send(16'h0003, 16'h0004, 1'b0, 1'b1);
        get_rsp("recov", 0);
        check_val("recov_on_cycles", on_cyc, 32'd2);
        check_val("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
